led_blink_sched: RTL and testbench

- Shares the board's single status LED between NREQ requesters; each requester asks for a burst of N blinks.
- Round-robin arbitration picks the next requester.
- A prescaler-timed FSM plays the burst, inserts an inter-burst gap, then re-arbitrates.
- Sits between the clk-domain status sources (UART, self-test, heartbeat) and the LED pin; replaces a free-running divider-bit LED drive.

---
 rtl/led_pkg.sv | 26 ++
 rtl/led_tick_gen.sv | 47 ++++
 rtl/led_blink_sched.sv | 204 ++++++++++++++++++++
 tb/tb_led_blink_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the status-LED blink scheduler.
//   led_state_t   : burst player states (IDLE, ON, OFF, GAP)
//   DEFAULT_CNT_W : default width of each requester's blink-count field
//   width_of()    : clog2-based field width that never collapses to zero bits,
//                   used for the prescaler, owner/pointer and gap counters
// -----------------------------------------------------------------------------
package led_pkg;

    localparam int DEFAULT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } led_state_t;

    // Number of bits needed to hold the values 0..n-1. A one-value range still
    // gets one bit so every derived vector has a legal width.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : led_pkg

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Prescaler that divides clk down to the LED phase rate.
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset (counter cleared)
//   restart  in   clears the counter on the next edge so a new burst starts
//                 its first phase on an exact tick boundary
//   tick     out  high during the single cycle the counter sits at TICK_DIV-1
// Parameter TICK_DIV (>= 2): clk cycles per tick.
// -----------------------------------------------------------------------------
module led_tick_gen
    import led_pkg::*;
#(
    parameter int TICK_DIV = 6000000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int              PW   = width_of(TICK_DIV);
    localparam logic [PW-1:0]   LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_reg;
    logic [PW-1:0] cnt_next;

    assign tick = (cnt_reg == LAST);

    // The counter wraps on its own tick; restart overrides so that the cycle
    // after restart always reads 0 regardless of where the counter was.
    always_comb begin
        cnt_next = cnt_reg + PW'(1);
        if (restart || tick) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule : led_tick_gen

// File: rtl/led_blink_sched.sv
// -----------------------------------------------------------------------------
// led_blink_sched
// Shares the single status LED between NREQ requesters. A round-robin arbiter
// picks a requester while idle, its blink count is captured, and a
// prescaler-timed FSM plays count blinks (one tick on, one tick off each),
// then holds the LED dark for GAP_TICKS ticks before arbitrating again.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous, active-high reset; aborts any burst, LED dark
//   req    in   [NREQ]        per-requester level request
//   count  in   [NREQ*CNT_W]  blink counts, requester i at [i*CNT_W +: CNT_W];
//                             only looked at in the cycle a request wins
//   grant  out  [NREQ]        one-hot, one-cycle pulse in the first cycle of
//                             the accepted burst
//   owner  out  [clog2(NREQ)] requester being (or last) served
//   busy   out  high whenever the FSM is not idle
//   led    out  LED drive, high = lit
//
// Parameters: NREQ (2..8), CNT_W, TICK_DIV (>= 2), GAP_TICKS (>= 1).
// -----------------------------------------------------------------------------
module led_blink_sched
    import led_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int CNT_W     = DEFAULT_CNT_W,
    parameter int TICK_DIV  = 6000000,
    parameter int GAP_TICKS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*CNT_W-1:0]     count,
    output logic [NREQ-1:0]           grant,
    output logic [width_of(NREQ)-1:0] owner,
    output logic                      busy,
    output logic                      led
);

    localparam int                IDX_W    = width_of(NREQ);
    localparam int                GAP_W    = width_of(GAP_TICKS);
    // NREQ held one bit wider than an index so ptr+1+offset never overflows.
    localparam logic [IDX_W:0]    NREQ_X   = (IDX_W + 1)'(NREQ);
    localparam logic [IDX_W-1:0]  PTR_INIT = IDX_W'(NREQ - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_TICKS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    led_state_t        state_reg;
    led_state_t        state_next;
    logic [CNT_W-1:0]  remaining_reg;
    logic [CNT_W-1:0]  remaining_next;
    logic [GAP_W-1:0]  gap_reg;
    logic [GAP_W-1:0]  gap_next;
    logic [IDX_W-1:0]  owner_reg;
    logic [IDX_W-1:0]  owner_next;
    logic [IDX_W-1:0]  ptr_reg;
    logic [IDX_W-1:0]  ptr_next;
    logic [NREQ-1:0]   grant_reg;
    logic [NREQ-1:0]   grant_next;

    logic              tick;
    logic              restart;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // Slot gi of the rotated view holds requester (ptr+1+gi) mod NREQ, so
    // the lowest asserted slot is the first requester after the pointer.
    // ------------------------------------------------------------------
    logic [NREQ-1:0]   req_rot;
    logic [IDX_W-1:0]  rot_idx [NREQ];
    logic              win_valid;
    logic [IDX_W-1:0]  win_idx;
    logic [CNT_W-1:0]  win_count;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        logic [IDX_W:0] sum;

        // sum < 2*NREQ, so one conditional subtraction is a full modulo.
        assign sum         = {1'b0, ptr_reg} + (IDX_W + 1)'(gi + 1);
        assign rot_idx[gi] = (sum >= NREQ_X) ? IDX_W'(sum - NREQ_X)
                                             : sum[IDX_W-1:0];
        assign req_rot[gi] = req[rot_idx[gi]];
    end

    // Scan from the far end so the nearest asserted slot is written last.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_valid = 1'b1;
                win_idx   = rot_idx[k];
            end
        end
    end

    assign win_count = count[win_idx*CNT_W +: CNT_W];

    // ------------------------------------------------------------------
    // Burst FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        gap_next       = gap_reg;
        owner_next     = owner_reg;
        ptr_next       = ptr_reg;
        grant_next     = '0;
        restart        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (win_valid) begin
                    // Restarting the prescaler here makes the grant cycle
                    // the first cycle of a full-length phase.
                    restart             = 1'b1;
                    grant_next[win_idx] = 1'b1;
                    owner_next          = win_idx;
                    ptr_next            = win_idx;
                    remaining_next      = win_count;
                    gap_next            = '0;
                    // A zero-count request still costs a grant and a gap.
                    state_next          = (win_count == '0) ? ST_GAP : ST_ON;
                end
            end

            ST_ON: begin
                if (tick) begin
                    state_next = ST_OFF;
                end
            end

            ST_OFF: begin
                // remaining is at least 1 here, so the decrement never wraps.
                if (tick) begin
                    remaining_next = remaining_reg - CNT_W'(1);
                    if (remaining_reg == CNT_W'(1)) begin
                        state_next = ST_GAP;
                        gap_next   = '0;
                    end else begin
                        state_next = ST_ON;
                    end
                end
            end

            ST_GAP: begin
                if (tick) begin
                    if (gap_reg == GAP_LAST) begin
                        state_next = ST_IDLE;
                    end else begin
                        gap_next = gap_reg + GAP_W'(1);
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Burst FSM: registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            gap_reg       <= '0;
            owner_reg     <= '0;
            ptr_reg       <= PTR_INIT;
            grant_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            gap_reg       <= gap_next;
            owner_reg     <= owner_next;
            ptr_reg       <= ptr_next;
            grant_reg     <= grant_next;
        end
    end

    // Outputs decode straight from registers, so they are glitch-free and
    // the LED is lit in the grant cycle itself.
    assign grant = grant_reg;
    assign owner = owner_reg;
    assign busy  = (state_reg != ST_IDLE);
    assign led   = (state_reg == ST_ON);

endmodule : led_blink_sched

// File: tb/tb_led_blink_sched.sv
// -----------------------------------------------------------------------------
// tb_led_blink_sched
// Self-checking bench for led_blink_sched with TICK_DIV=4, GAP_TICKS=2.
// The reference model treats each accepted burst as a timeline: a grant at
// cycle g with count n keeps busy high for (2n+GAP)*TICK_DIV cycles, and the
// LED is lit in every even TICK_DIV-long phase of the first 2n*TICK_DIV
// cycles. Directed scenarios pin the model with literal totals, followed by
// a randomized request/count/reset phase.
// -----------------------------------------------------------------------------
module tb_led_blink_sched;

    localparam int NREQ  = 4;
    localparam int CNT_W = 4;
    localparam int TD    = 4;
    localparam int GAP   = 2;

    logic                  clk   = 1'b0;
    logic                  rst   = 1'b1;
    logic [NREQ-1:0]       req   = '0;
    logic [NREQ*CNT_W-1:0] count = '0;
    logic [NREQ-1:0]       grant;
    logic [1:0]            owner;
    logic                  busy;
    logic                  led;

    always #5 clk = ~clk;

    led_blink_sched #(
        .NREQ      (NREQ),
        .CNT_W     (CNT_W),
        .TICK_DIV  (TD),
        .GAP_TICKS (GAP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .count (count),
        .grant (grant),
        .owner (owner),
        .busy  (busy),
        .led   (led)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model state and observation totals
    // ------------------------------------------------------------------
    int              t        = 0;
    bit              m_active = 1'b0;
    int              m_g      = 0;
    int              m_n      = 0;
    int              m_w      = 0;
    int              m_len    = 0;
    int              m_owner  = 0;
    int              m_ptr    = NREQ - 1;

    int              obs_led_hi = 0;
    int              obs_busy   = 0;
    int              obs_grants = 0;
    logic [NREQ-1:0] obs_gq [$];
    int              obs_oq [$];

    // Compare process: one check set per cycle, on the falling edge.
    initial begin
        int              rel;
        int              w;
        int              idx;
        logic            exp_led;
        logic            exp_busy;
        logic [NREQ-1:0] exp_grant;
        int              exp_owner;
        forever begin
            @(negedge clk);
            t++;
            if (rst) begin
                m_active  = 1'b0;
                m_owner   = 0;
                m_ptr     = NREQ - 1;
                exp_led   = 1'b0;
                exp_busy  = 1'b0;
                exp_grant = '0;
                exp_owner = 0;
            end else begin
                if (m_active && t >= m_g + m_len) m_active = 1'b0;
                if (m_active) begin
                    rel       = t - m_g;
                    exp_busy  = 1'b1;
                    exp_led   = (rel < 2 * m_n * TD) && ((rel / TD) % 2 == 0);
                    exp_grant = (rel == 0) ? (NREQ'(1) << m_w) : '0;
                    exp_owner = m_w;
                end else begin
                    exp_busy  = 1'b0;
                    exp_led   = 1'b0;
                    exp_grant = '0;
                    exp_owner = m_owner;
                end
            end
            chk("led",   32'(led),   32'(exp_led));
            chk("busy",  32'(busy),  32'(exp_busy));
            chk("grant", 32'(grant), 32'(exp_grant));
            chk("owner", 32'(owner), exp_owner);

            if (!rst) begin
                if (led)  obs_led_hi++;
                if (busy) obs_busy++;
                if (grant != '0) begin
                    obs_grants++;
                    obs_gq.push_back(grant);
                    obs_oq.push_back(int'(owner));
                    $display("grant t=%0d vec=%b owner=%0d", t, grant, owner);
                end
            end

            // Idle this cycle with a pending request: burst starts next cycle.
            if (!rst && !m_active && req != '0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (w < 0 && req[idx]) w = idx;
                end
                m_active = 1'b1;
                m_g      = t + 1;
                m_w      = w;
                m_n      = int'(count[w*CNT_W +: CNT_W]);
                m_len    = (2 * m_n + GAP) * TD;
                m_ptr    = w;
                m_owner  = w;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_led_hi = 0;
        obs_busy   = 0;
        obs_grants = 0;
        obs_gq.delete();
        obs_oq.delete();
    endtask

    task automatic pulse_req(input logic [NREQ-1:0] r);
        req = r;
        step(1);
        req = '0;
    endtask

    logic [NREQ-1:0] rr_exp_g [4];
    int              rr_exp_o [4];
    logic [31:0]     act_v;

    initial begin
        rr_exp_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        rr_exp_o = '{0, 1, 3, 0};

        step(3);

        // --- Reset mid-burst -------------------------------------------
        count       = '0;
        count[3:0]  = 4'd3;
        req         = 4'b0001;
        rst         = 1'b0;
        step(7);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_led",   32'(led),   32'd0);
        chk("async_rst_busy",  32'(busy),  32'd0);
        chk("async_rst_grant", 32'(grant), 32'd0);
        step(2);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_idle_busy",  32'(busy),  32'd0);
        chk("post_rst_idle_grant", 32'(grant), 32'd0);
        @(negedge clk); #1;
        chk("post_rst_regrant", 32'(grant), 32'b0001);
        step(1);
        req = '0;
        step(40);

        // --- Single burst of 3 -----------------------------------------
        clear_obs();
        count      = '0;
        count[3:0] = 4'd3;
        pulse_req(4'b0001);
        step(40);
        chk("single_led_hi", obs_led_hi, 12);
        chk("single_busy",   obs_busy,   32);
        chk("single_grants", obs_grants, 1);
        act_v = (obs_gq.size() > 0) ? 32'(obs_gq[0]) : 32'hFFFF_FFFF;
        chk("single_grant_vec", act_v, 32'b0001);

        // --- Round robin from a fresh pointer --------------------------
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        clear_obs();
        count = {4{4'd1}};
        req   = 4'b1011;
        step(72);
        req   = '0;
        step(30);
        for (int i = 0; i < 4; i++) begin
            act_v = (i < obs_gq.size()) ? 32'(obs_gq[i]) : 32'hFFFF_FFFF;
            chk($sformatf("rr_grant%0d", i), act_v, 32'(rr_exp_g[i]));
            act_v = (i < obs_oq.size()) ? 32'(obs_oq[i]) : 32'hFFFF_FFFF;
            chk($sformatf("rr_owner%0d", i), act_v, rr_exp_o[i]);
        end

        // --- Zero count -------------------------------------------------
        clear_obs();
        count = '0;
        pulse_req(4'b0100);
        step(20);
        chk("zero_led_hi", obs_led_hi, 0);
        chk("zero_busy",   obs_busy,   GAP * TD);
        chk("zero_grants", obs_grants, 1);
        act_v = (obs_gq.size() > 0) ? 32'(obs_gq[0]) : 32'hFFFF_FFFF;
        chk("zero_grant_vec", act_v, 32'b0100);

        // --- Request drop and count change after grant -----------------
        clear_obs();
        count      = '0;
        count[3:0] = 4'd2;
        req        = 4'b0001;
        step(1);
        req        = '0;
        count[3:0] = 4'd7;
        step(35);
        chk("drop_led_hi", obs_led_hi, 8);
        chk("drop_busy",   obs_busy,   24);
        chk("drop_grants", obs_grants, 1);

        // --- Maximum count ---------------------------------------------
        clear_obs();
        count      = '0;
        count[3:0] = 4'd15;
        pulse_req(4'b0001);
        step(140);
        chk("max_led_hi", obs_led_hi, 60);
        chk("max_busy",   obs_busy,   128);
        chk("max_grants", obs_grants, 1);
        chk("max_idle",   32'(busy),  32'd0);

        // --- Randomized traffic ----------------------------------------
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) req = NREQ'($urandom);
            for (int k = 0; k < NREQ; k++) count[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 3));
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                step($urandom_range(1, 2));
                rst = 1'b0;
            end
            step(1);
        end
        req = '0;
        step(60);
        chk("final_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_led_blink_sched
